alu_dispatch: RTL and testbench
===============================

// Module: alu_dispatch
// PURPOSE
//   Parametrised ALU unit dispatcher: decodes funct7 of each accepted op against a per-unit match table,
//   drives one-hot unit select plus a 1-cycle start pulse, and tracks multi-cycle units (e.g. MUL/DIV) until done.
//   Sits between decode and the ALU units (base, extra, mul/div); adds valid/ready, illegal-op and watchdog reporting.
// PARAMETERS
//   NUM_UNITS        3                          number of ALU units / select lines
//   FUNCT7_TABLE     {7'h01,7'h20,7'h00}        packed 7*NUM_UNITS; unit i matches bits [7i+6:7i]
//   MULTICYCLE_MASK  3'b100                     bit i=1: unit i is multi-cycle, completion signalled by unit_done[i]
//   TIMEOUT          64                         max WAIT cycles before abort; 0 disables watchdog
// PORTS
//   clock         in   1          rising-edge clock
//   reset_n       in   1          asynchronous reset, active low
//   enable        in   1          global advance; low = stall (all state held, pulses forced 0)
//   in_valid      in   1          op presented
//   in_ready      out  1          op can be accepted (combinational: enable & state==IDLE)
//   funct7        in   7          op class field, sampled on accept
//   unit_sel      out  NUM_UNITS  registered one-hot of current/most recent unit
//   unit_start    out  NUM_UNITS  1-cycle start pulse to selected unit
//   unit_done     in   NUM_UNITS  completion from multi-cycle units
//   result_valid  out  1          1-cycle pulse: op complete
//   illegal       out  1          1-cycle pulse: accepted funct7 matched no table entry
//   timeout       out  1          1-cycle pulse: multi-cycle unit exceeded TIMEOUT
//   busy          out  1          state==WAIT
// BEHAVIOUR
//   Reset: state=IDLE, counter=0; unit_sel, unit_start, result_valid, illegal, timeout, busy all 0.
//   Reset mid-WAIT: immediate return to IDLE; no start reissued, no result_valid/timeout.
//   Accept = in_valid & in_ready at rising edge. Decode: lowest index i with table entry == funct7 wins.
//   FSM IDLE:
//     - no match: next cycle illegal=1, unit_sel<=0, unit_start=0; stay IDLE.
//     - match, single-cycle unit: next cycle unit_sel<=onehot(i), unit_start[i]=1, result_valid=1; stay IDLE
//       (latency 1; back-to-back accepts every cycle allowed).
//     - match, multi-cycle unit: next cycle unit_sel<=onehot(i), unit_start[i]=1; go WAIT, counter<=0.
//   FSM WAIT: in_ready=0; counter +1 per enabled cycle.
//     - unit_done[sel] sampled high: next cycle result_valid=1, go IDLE, unit_sel held.
//     - unit_done of non-selected units ignored in every state.
//     - counter==TIMEOUT-1 with no done (TIMEOUT>0): next cycle timeout=1, unit_sel<=0, go IDLE.
//     - done and timeout same cycle: done wins (result_valid, no timeout).
//     - unit_done[sel] in the start cycle itself is honoured (complete in 2 cycles).
//   unit_sel holds last value in IDLE until next accept, illegal or timeout.
//   Counter width $clog2(TIMEOUT+1), saturating; no wrap.
//   enable=0: no accept, counter frozen, FSM frozen, unit_done ignored (units must hold done until enable).
//   At most one of result_valid/illegal/timeout high in any cycle.
// TESTING
//   1 reset_n low mid-op -> all outputs 0 asynchronously; after release in_ready=enable.
//   2 funct7=7'h00 accept -> next cycle unit_sel=3'b001, unit_start=3'b001, result_valid=1; funct7=7'h20 -> 3'b010.
//   3 funct7=7'h01 accept, unit_done[2] 5 cycles later -> busy 1 for 5 cycles, result_valid 1 cycle after done, in_ready=0 meanwhile.
//   4 funct7=7'h7F -> illegal pulse 1 cycle, unit_sel=0, no start, in_ready stays 1.
//   5 funct7=7'h01, no done, TIMEOUT=64 -> timeout pulse 64 cycles after start, unit_sel=0; done on same cycle -> result_valid, no timeout.
//   6 enable toggled low during WAIT and across back-to-back single-cycle ops -> counter/state frozen, no pulses, no lost or duplicated ops.

Source files
------------

// File: rtl/alu_dispatch.sv
// ALU dispatcher: decodes funct7 against a per-unit match table, issues a one-hot
// select plus start pulse, and tracks multi-cycle units until done or watchdog expiry.

// Per-unit table slice: one comparator per ALU unit.
module alu_dispatch_lane #(
    parameter logic [6:0] ENTRY = 7'h00
) (
    input  logic [6:0] funct7,
    output logic       match
);
    assign match = (funct7 == ENTRY);
endmodule

module alu_dispatch #(
    parameter int                     NUM_UNITS       = 3,
    parameter logic [7*NUM_UNITS-1:0] FUNCT7_TABLE    = {7'h01, 7'h20, 7'h00},
    parameter logic [NUM_UNITS-1:0]   MULTICYCLE_MASK = 3'b100,
    parameter int                     TIMEOUT         = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           funct7,
    output logic [NUM_UNITS-1:0] unit_sel,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 result_valid,
    output logic                 illegal,
    output logic                 timeout,
    output logic                 busy
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [NUM_UNITS-1:0] match;
    logic [NUM_UNITS-1:0] dec_oh;
    logic                 hit;
    logic                 dec_multi;
    logic                 done_sel;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
        alu_dispatch_lane #(.ENTRY(FUNCT7_TABLE[7*i +: 7])) u_lane (
            .funct7 (funct7),
            .match  (match[i])
        );
    end

    // Isolating the lowest set bit gives lowest-index-wins priority.
    assign dec_oh    = match & (~match + NUM_UNITS'(1));
    assign hit       = |match;
    assign dec_multi = |(dec_oh & MULTICYCLE_MASK);
    assign done_sel  = |(unit_done & unit_sel);

    assign in_ready = enable && (state == S_IDLE);
    assign busy     = (state == S_WAIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            count        <= '0;
            unit_sel     <= '0;
            unit_start   <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // Pulses last one cycle; a stalled cycle holds state but emits nothing.
            unit_start   <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            timeout      <= 1'b0;
            if (enable) begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (!hit) begin
                                illegal  <= 1'b1;
                                unit_sel <= '0;
                            end else begin
                                unit_sel   <= dec_oh;
                                unit_start <= dec_oh;
                                if (dec_multi) begin
                                    state <= S_WAIT;
                                    count <= '0;
                                end else begin
                                    result_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        // Done is checked first so it wins over a coincident expiry.
                        if (done_sel) begin
                            result_valid <= 1'b1;
                            state        <= S_IDLE;
                        end else if (TIMEOUT > 0 && count == CNT_LAST) begin
                            timeout  <= 1'b1;
                            unit_sel <= '0;
                            state    <= S_IDLE;
                        end else if (count != CNT_MAX) begin
                            count <= count + CW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: driver pushes expected pulse events, a negedge
// monitor pops and compares whenever the DUT emits a pulse.
module tb_alu_dispatch;
    localparam int TIMEOUT = 64;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] funct7 = '0;
    logic [2:0] unit_done = '0;
    logic       in_ready, result_valid, illegal, timeout, busy;
    logic [2:0] unit_sel, unit_start;

    alu_dispatch #(
        .NUM_UNITS(3), .FUNCT7_TABLE({7'h01, 7'h20, 7'h00}),
        .MULTICYCLE_MASK(3'b100), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .funct7(funct7), .unit_sel(unit_sel),
        .unit_start(unit_start), .unit_done(unit_done), .result_valid(result_valid),
        .illegal(illegal), .timeout(timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] start;
        logic       rv, ill, to;
        logic [2:0] sel;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [2:0] exp_sel = '0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unit i is addressed by its table entry; first entry in index order wins.
    function automatic int decode(input logic [6:0] f);
        logic [6:0] tbl [3];
        tbl[0] = 7'h00; tbl[1] = 7'h20; tbl[2] = 7'h01;
        for (int i = 0; i < 3; i++) if (tbl[i] == f) return i;
        return -1;
    endfunction

    task automatic push(input logic [2:0] st, input logic rv, input logic ill,
                        input logic to, input logic [2:0] sel);
        exp_t e;
        e.start = st; e.rv = rv; e.ill = ill; e.to = to; e.sel = sel; e.due = cyc;
        q.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the scoreboard, on its due cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_sel = '0;
            q.delete();
        end else begin
            if (|unit_start || result_valid || illegal || timeout) begin
                chk("pulse_exclusive", 32'(result_valid + illegal + timeout) <= 1, 1);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {unit_start, result_valid, illegal, timeout}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event", {unit_start, result_valid, illegal, timeout},
                        {e.start, e.rv, e.ill, e.to});
                    chk("event_cycle", cyc, e.due);
                    exp_sel = e.sel;
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                chk("missing_event", 0, {q[0].start, q[0].rv, q[0].ill, q[0].to});
                void'(q.pop_front());
            end
            chk("unit_sel", unit_sel, exp_sel);
        end
    end

    // Issue one op; d = cycles after start before done is raised (-1: never).
    task automatic issue(input logic [6:0] f, input int d, input int stall);
        int         u, n;
        bit         got;
        logic [2:0] oh;
        u  = decode(f);
        oh = (u >= 0) ? 3'(1 << u) : 3'b000;
        in_valid = 1'b1;
        funct7   = f;
        got      = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            enable    = ($urandom_range(99) >= stall);
            unit_done = 3'($urandom_range(7));
            #1 chk("in_ready_idle", in_ready, enable);
            @(posedge clock); #1;
            if (enable) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_bound", 0, 1);
        if (u < 0) push(3'b000, 1'b0, 1'b1, 1'b0, 3'b000);
        else if (u != 2) push(oh, 1'b1, 1'b0, 1'b0, oh);
        else begin
            push(oh, 1'b0, 1'b0, 1'b0, oh);
            n = 0;
            for (int k = 0; k < 2000; k++) begin
                enable       = ($urandom_range(99) >= stall);
                unit_done    = {(d >= 0 && k >= d), 2'($urandom_range(3))};
                #1 chk("wait_status", {busy, in_ready}, 2'b10);
                @(posedge clock); #1;
                if (enable) begin
                    n++;
                    if (unit_done[2]) begin
                        push(3'b000, 1'b1, 1'b0, 1'b0, oh);
                        break;
                    end else if (n == TIMEOUT) begin
                        push(3'b000, 1'b0, 1'b0, 1'b1, 3'b000);
                        break;
                    end
                end
            end
            unit_done = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        logic [6:0] f;
        // Power-on reset
        #3 chk("reset_outputs", {unit_sel, unit_start, result_valid, illegal, timeout, busy}, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        enable = 1'b1;
        #1 chk("ready_after_reset", in_ready, 1);

        // Single-cycle units, back to back, then an unmatched funct7
        @(posedge clock); #1;
        issue(7'h00, 0, 0);
        issue(7'h20, 0, 0);
        issue(7'h00, 0, 0);
        issue(7'h7F, 0, 0);
        issue(7'h20, 0, 0);

        // Multi-cycle: done 4 cycles after start, done in the start cycle itself
        issue(7'h01, 4, 0);
        issue(7'h01, 0, 0);
        // Watchdog expiry, then done landing exactly on the expiry cycle
        issue(7'h01, -1, 0);
        issue(7'h01, TIMEOUT - 1, 0);
        issue(7'h00, 0, 0);

        // Stalls during WAIT, across back-to-back singles, and during a timeout
        issue(7'h01, 10, 40);
        for (int i = 0; i < 8; i++) issue((i % 2) ? 7'h20 : 7'h00, 0, 40);
        issue(7'h01, -1, 30);

        // Reset while waiting on a multi-cycle unit
        enable   = 1'b1;
        in_valid = 1'b1;
        funct7   = 7'h01;
        unit_done = '0;
        @(posedge clock); #1;
        push(3'b100, 1'b0, 1'b0, 1'b0, 3'b100);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 chk("async_reset_outputs",
               {unit_sel, unit_start, result_valid, illegal, timeout, busy}, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1 chk("ready_after_midop_reset", in_ready, 1);
        enable = 1'b0;
        #1 chk("ready_gated_by_enable", in_ready, 0);
        enable    = 1'b1;
        unit_done = 3'b111;
        repeat (3) @(posedge clock);
        #1 unit_done = '0;

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(3))
                0: f = 7'h00;
                1: f = 7'h20;
                2: f = 7'h01;
                default: f = 7'($urandom_range(127));
            endcase
            issue(f, $urandom_range(20), 25);
        end

        enable = 1'b1;
        repeat (5) @(posedge clock);
        #1 chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
